// File: rtl/lsu_arbiter_pkg.sv
// Shared definitions for the LSU arbiter: RV32I load/store funct3 codes,
// FSM state encoding and the data-request funct3 legality check.
package lsu_arbiter_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    // Starvation counter width; covers STARVE_MAX up to 15.
    localparam int STARVE_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    function automatic logic funct3_legal(input logic wren, input logic [2:0] f3);
        if (wren) begin
            return (f3 == SB) || (f3 == SH) || (f3 == SW);
        end
        return (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
    endfunction

endpackage

// File: rtl/lsu_arbiter_if.sv
// Requester-side and LoadStoreUnit-side signals of the LSU arbiter.
// The arbiter uses the slave modport; the surrounding pipeline/LSU the master one.
interface lsu_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              ifReqValid;
    logic              ifReqReady;
    logic [ADDR_W-1:0] ifAddr;
    logic              ifRspValid;
    logic [DATA_W-1:0] ifRspData;

    logic              dReqValid;
    logic              dReqReady;
    logic [ADDR_W-1:0] dAddr;
    logic              dWren;
    logic [2:0]        dFunct3;
    logic [DATA_W-1:0] dWdata;
    logic              dRspValid;
    logic [DATA_W-1:0] dRspData;
    logic              dErr;

    logic [ADDR_W-1:0] lsuAddress;
    logic              lsuWren;
    logic [2:0]        lsuFunct3;
    logic [DATA_W-1:0] lsuDIn;
    logic [DATA_W-1:0] lsuDOut;

    modport slave (
        input  ifReqValid, ifAddr,
        input  dReqValid, dAddr, dWren, dFunct3, dWdata,
        input  lsuDOut,
        output ifReqReady, ifRspValid, ifRspData,
        output dReqReady, dRspValid, dRspData, dErr,
        output lsuAddress, lsuWren, lsuFunct3, lsuDIn
    );

    modport master (
        output ifReqValid, ifAddr,
        output dReqValid, dAddr, dWren, dFunct3, dWdata,
        output lsuDOut,
        input  ifReqReady, ifRspValid, ifRspData,
        input  dReqReady, dRspValid, dRspData, dErr,
        input  lsuAddress, lsuWren, lsuFunct3, lsuDIn
    );

endinterface

// File: rtl/lsu_arb_prio.sv
// Fetch/data grant logic: data has priority unless fetch has lost STARVE_MAX
// consecutive IDLE arbitrations, in which case fetch is forced through.
module lsu_arb_prio
    import lsu_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic idle,
    input  logic if_valid,
    input  logic d_valid,
    output logic gnt_if,
    output logic gnt_d
);

    localparam logic [STARVE_W-1:0] CNT_MAX = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve_cnt_reg;
    logic [STARVE_W-1:0] starve_cnt_next;
    logic                force_if;

    always_comb begin
        force_if        = (starve_cnt_reg == CNT_MAX);
        gnt_if          = idle & if_valid & (~d_valid | force_if);
        gnt_d           = idle & d_valid & ~(if_valid & force_if);
        starve_cnt_next = starve_cnt_reg;
        // The count only moves while arbitrating; busy cycles leave it alone.
        if (idle) begin
            if (!if_valid || gnt_if) begin
                starve_cnt_next = '0;
            end else if (starve_cnt_reg < CNT_MAX) begin
                starve_cnt_next = starve_cnt_reg + STARVE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_reg <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end

endmodule

// File: rtl/lsu_arbiter.sv
// Shares one LoadStoreUnit between instruction fetch and the data path.
// One access at a time: accept (IDLE) -> drive LSU (ISSUE) -> respond (RESP).
module lsu_arbiter
    import lsu_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    lsu_arbiter_if.slave bus
);

    state_t            state_reg;
    state_t            state_next;
    logic              idle;
    logic              gnt_if;
    logic              gnt_d;
    logic              accept;

    owner_t            owner_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [2:0]        f3_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              wren_reg;
    logic              err_reg;

    logic [DATA_W-1:0] if_rsp_data_reg;
    logic [DATA_W-1:0] d_rsp_data_reg;
    logic [DATA_W-1:0] d_rsp_value;

    logic              lsu_wren;
    logic              if_rsp_valid;
    logic              d_rsp_valid;

    assign idle   = (state_reg == IDLE);
    assign accept = gnt_if | gnt_d;

    lsu_arb_prio #(
        .STARVE_MAX(STARVE_MAX)
    ) u_prio (
        .clk      (clk),
        .rst_n    (rst_n),
        .idle     (idle),
        .if_valid (bus.ifReqValid),
        .d_valid  (bus.dReqValid),
        .gnt_if   (gnt_if),
        .gnt_d    (gnt_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        lsu_wren     = 1'b0;
        if_rsp_valid = 1'b0;
        d_rsp_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                // An illegal funct3 still walks through ISSUE but never writes.
                lsu_wren   = wren_reg & ~err_reg;
                state_next = RESP;
            end
            RESP: begin
                if_rsp_valid = (owner_reg == OWN_FETCH);
                d_rsp_valid  = (owner_reg == OWN_DATA);
                state_next   = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request latch: requester inputs are free to change after the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_reg <= OWN_FETCH;
            addr_reg  <= '0;
            f3_reg    <= '0;
            wdata_reg <= '0;
            wren_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else if (gnt_d) begin
            owner_reg <= OWN_DATA;
            addr_reg  <= bus.dAddr;
            f3_reg    <= bus.dFunct3;
            wdata_reg <= bus.dWdata;
            wren_reg  <= bus.dWren;
            err_reg   <= ~funct3_legal(bus.dWren, bus.dFunct3);
        end else if (gnt_if) begin
            owner_reg <= OWN_FETCH;
            addr_reg  <= bus.ifAddr;
            f3_reg    <= LW;
            wdata_reg <= '0;
            wren_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end
    end

    // Stores and rejected requests return zero rather than whatever the LSU drives.
    assign d_rsp_value = (wren_reg || err_reg) ? '0 : bus.lsuDOut;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rsp_data_reg <= '0;
            d_rsp_data_reg  <= '0;
        end else if (state_reg == RESP) begin
            if (owner_reg == OWN_DATA) begin
                d_rsp_data_reg <= d_rsp_value;
            end else begin
                if_rsp_data_reg <= bus.lsuDOut;
            end
        end
    end

    assign bus.ifReqReady = gnt_if;
    assign bus.dReqReady  = gnt_d;

    // The response is visible in the pulse cycle; the register then holds it.
    assign bus.ifRspValid = if_rsp_valid;
    assign bus.ifRspData  = if_rsp_valid ? bus.lsuDOut : if_rsp_data_reg;
    assign bus.dRspValid  = d_rsp_valid;
    assign bus.dRspData   = d_rsp_valid ? d_rsp_value : d_rsp_data_reg;
    assign bus.dErr       = d_rsp_valid & err_reg;

    assign bus.lsuAddress = addr_reg;
    assign bus.lsuWren    = lsu_wren;
    assign bus.lsuFunct3  = f3_reg;
    assign bus.lsuDIn     = wdata_reg;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Self-checking bench for lsu_arbiter: a small word memory stands in for the
// LoadStoreUnit, and a cycle-level reference model checks every output.
module tb_lsu_arbiter;

    localparam int STARVE = 4;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    lsu_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    lsu_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .STARVE_MAX(STARVE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ld(input logic [31:0] w, input logic [2:0] f3);
        case (f3)
            3'd0:    return {{24{w[7]}}, w[7:0]};
            3'd1:    return {{16{w[15]}}, w[15:0]};
            3'd4:    return {24'd0, w[7:0]};
            3'd5:    return {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] st(input logic [31:0] old, input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'd0:    return {old[31:8], d[7:0]};
            3'd1:    return {old[31:16], d[15:0]};
            default: return d;
        endcase
    endfunction

    function automatic bit legal_req(input bit wr, input logic [2:0] f3);
        if (wr) return f3 inside {3'd0, 3'd1, 3'd2};
        return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    endfunction

    // LoadStoreUnit stand-in: dOut is the word read at the previous edge.
    logic [31:0] lsu_mem [16];
    bit          lsu_init = 1'b0;
    always @(posedge clk) begin
        if (!lsu_init) begin
            for (int i = 0; i < 16; i++) lsu_mem[i] <= 32'd0;
            lsu_init     <= 1'b1;
            bus.lsuDOut  <= 32'd0;
        end else begin
            if (bus.lsuWren)
                lsu_mem[bus.lsuAddress[3:0]] <= st(lsu_mem[bus.lsuAddress[3:0]], bus.lsuFunct3, bus.lsuDIn);
            bus.lsuDOut <= ld(lsu_mem[bus.lsuAddress[3:0]], bus.lsuFunct3);
        end
    end

    // Reference model: accept at cycle A -> LSU write at A+1, response at A+2, free at A+3.
    logic [31:0] ref_mem [16];
    bit          ref_init = 1'b0;
    int          cyc, acc_c, starve;
    bit          p_fetch, p_wren, p_legal;
    logic [31:0] p_addr, p_wdata, p_rsp;
    logic [2:0]  p_f3;
    logic [31:0] held_if, held_d;

    always @(negedge clk) begin : model_blk
        bit free, win_f, win_d, at_iss, at_rsp;
        if (!rst_n) begin
            if (!ref_init) begin
                for (int i = 0; i < 16; i++) ref_mem[i] = 32'd0;
                ref_init = 1'b1;
            end
            cyc = 0; acc_c = -10; starve = 0;
            held_if = 32'd0; held_d = 32'd0;
            p_fetch = 1'b0; p_wren = 1'b0; p_legal = 1'b1;
            p_addr = 32'd0; p_wdata = 32'd0; p_rsp = 32'd0; p_f3 = 3'd0;
        end else begin
            free   = (cyc - acc_c) >= 3;
            at_iss = (cyc == acc_c + 1);
            at_rsp = (cyc == acc_c + 2);
            win_f  = free && bus.ifReqValid && (!bus.dReqValid || starve == STARVE);
            win_d  = free && bus.dReqValid && !win_f;

            check("m_if_ready", 32'(bus.ifReqReady), 32'(win_f));
            check("m_d_ready", 32'(bus.dReqReady), 32'(win_d));
            check("m_lsu_wren", 32'(bus.lsuWren), 32'(at_iss && !p_fetch && p_wren && p_legal));
            if (at_iss || at_rsp) begin
                check("m_lsu_addr", bus.lsuAddress, p_addr);
                check("m_lsu_f3", 32'(bus.lsuFunct3), 32'(p_f3));
                if (!p_fetch && p_wren) check("m_lsu_din", bus.lsuDIn, p_wdata);
            end
            check("m_if_rsp_valid", 32'(bus.ifRspValid), 32'(at_rsp && p_fetch));
            check("m_d_rsp_valid", 32'(bus.dRspValid), 32'(at_rsp && !p_fetch));
            check("m_d_err", 32'(bus.dErr), 32'(at_rsp && !p_fetch && !p_legal));
            check("m_if_rsp_data", bus.ifRspData, (at_rsp && p_fetch) ? p_rsp : held_if);
            check("m_d_rsp_data", bus.dRspData, (at_rsp && !p_fetch) ? p_rsp : held_d);

            if (at_iss) begin
                if (p_wren && p_legal) begin
                    ref_mem[p_addr[3:0]] = st(ref_mem[p_addr[3:0]], p_f3, p_wdata);
                    p_rsp = 32'd0;
                end else if (p_legal) begin
                    p_rsp = ld(ref_mem[p_addr[3:0]], p_f3);
                end else begin
                    p_rsp = 32'd0;
                end
            end
            if (at_rsp) begin
                if (p_fetch) held_if = p_rsp;
                else         held_d  = p_rsp;
            end
            if (free) begin
                if (bus.ifReqValid && !win_f) starve = (starve < STARVE) ? starve + 1 : starve;
                else                          starve = 0;
                if (win_f) begin
                    acc_c = cyc; p_fetch = 1'b1; p_addr = bus.ifAddr; p_f3 = 3'b010;
                    p_wren = 1'b0; p_wdata = 32'd0; p_legal = 1'b1;
                end else if (win_d) begin
                    acc_c = cyc; p_fetch = 1'b0; p_addr = bus.dAddr; p_f3 = bus.dFunct3;
                    p_wren = bus.dWren; p_wdata = bus.dWdata; p_legal = legal_req(bus.dWren, bus.dFunct3);
                end
            end
            cyc++;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_if_ready"}, 32'(bus.ifReqReady), 32'd0);
        check({tag, "_d_ready"}, 32'(bus.dReqReady), 32'd0);
        check({tag, "_if_rsp"}, {31'd0, bus.ifRspValid} | bus.ifRspData, 32'd0);
        check({tag, "_d_rsp"}, {30'd0, bus.dRspValid, bus.dErr} | bus.dRspData, 32'd0);
        check({tag, "_lsu_addr"}, bus.lsuAddress, 32'd0);
        check({tag, "_lsu_ctl"}, {28'd0, bus.lsuWren, bus.lsuFunct3}, 32'd0);
        check({tag, "_lsu_din"}, bus.lsuDIn, 32'd0);
    endtask

    // One data access; returns what was seen at T+1 (issue) and T+2 (response).
    task automatic data_op(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, output logic [31:0] rdata, output logic rerr,
                           output logic saw_wren, output logic [31:0] saw_addr);
        bit got = 1'b0;
        @(posedge clk); #1;
        bus.dReqValid = 1'b1; bus.dWren = wr; bus.dFunct3 = f3; bus.dAddr = a; bus.dWdata = wd;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = bus.dReqReady;
        end
        check("d_accept", 32'(got), 32'd1);
        @(posedge clk); #1;
        bus.dReqValid = 1'b0; bus.dAddr = $urandom_range(0, 15); bus.dWdata = $urandom;
        @(negedge clk);
        saw_wren = bus.lsuWren;
        saw_addr = bus.lsuAddress;
        @(negedge clk);
        check("d_rsp_valid_t2", 32'(bus.dRspValid), 32'd1);
        rdata = bus.dRspData;
        rerr  = bus.dErr;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] rd, sa;
        logic        er, sw;
        string       order;
        bit          got;
        int          last, nacc;
        bit          prev_rsp;

        rst_n = 1'b0;
        bus.ifReqValid = 1'b0; bus.ifAddr = 32'd0;
        bus.dReqValid = 1'b0; bus.dAddr = 32'd0; bus.dWren = 1'b0;
        bus.dFunct3 = 3'd0; bus.dWdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Store then sub-word loads of the same word.
        data_op(1'b1, 3'b010, 32'd1, 32'hF0F0F0F0, rd, er, sw, sa);
        check("sw_issue_wren", 32'(sw), 32'd1);
        check("sw_issue_addr", sa, 32'd1);
        check("sw_rsp_data", rd, 32'd0);
        check("sw_rsp_err", 32'(er), 32'd0);
        data_op(1'b0, 3'b001, 32'd1, 32'd0, rd, er, sw, sa);
        check("lh_data", rd, 32'hFFFFF0F0);
        check("lh_issue_wren", 32'(sw), 32'd0);
        data_op(1'b0, 3'b100, 32'd1, 32'd0, rd, er, sw, sa);
        check("lbu_data", rd, 32'h000000F0);

        // Both requesters valid continuously: starvation forces every fifth grant.
        @(posedge clk); #1;
        bus.ifReqValid = 1'b1; bus.ifAddr = 32'd1;
        bus.dReqValid = 1'b1; bus.dWren = 1'b0; bus.dFunct3 = 3'b010; bus.dAddr = 32'd1;
        order = "";
        for (int i = 0; i < 60 && order.len() < 10; i++) begin
            @(negedge clk);
            if (bus.dReqReady) order = {order, "D"};
            else if (bus.ifReqReady) order = {order, "F"};
        end
        @(posedge clk); #1;
        bus.ifReqValid = 1'b0; bus.dReqValid = 1'b0;
        n_checks++;
        if (order != "DDDDFDDDDF") begin
            n_fail++;
            $display("FAIL grant_order: got %s expected DDDDFDDDDF", order);
        end
        repeat (3) @(negedge clk);
        check("fetch_word", bus.ifRspData, 32'hF0F0F0F0);

        // Illegal funct3 store: accepted, no write, error response.
        data_op(1'b1, 3'b011, 32'd1, 32'h0BADF00D, rd, er, sw, sa);
        check("bad_f3_wren", 32'(sw), 32'd0);
        check("bad_f3_err", 32'(er), 32'd1);
        check("bad_f3_data", rd, 32'd0);
        data_op(1'b0, 3'b010, 32'd1, 32'd0, rd, er, sw, sa);
        check("bad_f3_mem_kept", rd, 32'hF0F0F0F0);

        // Reset in the ISSUE cycle of a store abandons it without writing.
        @(posedge clk); #1;
        bus.dReqValid = 1'b1; bus.dWren = 1'b1; bus.dFunct3 = 3'b010;
        bus.dAddr = 32'd2; bus.dWdata = 32'h12345678;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = bus.dReqReady;
        end
        check("rst_accept", 32'(got), 32'd1);
        @(posedge clk); #1;
        check("rst_issue_wren", 32'(bus.lsuWren), 32'd1);
        bus.dReqValid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        data_op(1'b0, 3'b010, 32'd2, 32'd0, rd, er, sw, sa);
        check("rst_store_dropped", rd, 32'd0);
        check("rst_next_err", 32'(er), 32'd0);

        // Back-to-back held request: accepts exactly three cycles apart.
        @(posedge clk); #1;
        bus.dReqValid = 1'b1; bus.dWren = 1'b0; bus.dFunct3 = 3'b010; bus.dAddr = 32'd1;
        last = -1; nacc = 0; prev_rsp = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (bus.dReqReady) begin
                if (last >= 0) check("b2b_spacing", 32'(k - last), 32'd3);
                last = k;
                nacc++;
            end
            check("b2b_rsp_gap", 32'(prev_rsp && bus.dRspValid), 32'd0);
            prev_rsp = bus.dRspValid;
        end
        check("b2b_count", 32'(nacc), 32'd6);
        @(posedge clk); #1;
        bus.dReqValid = 1'b0;
        repeat (3) @(posedge clk);

        // Randomized traffic against the reference model.
        repeat (800) begin
            @(posedge clk); #1;
            bus.ifReqValid = ($urandom_range(0, 3) != 0);
            bus.ifAddr     = $urandom_range(0, 15);
            bus.dReqValid  = ($urandom_range(0, 2) != 0);
            bus.dAddr      = $urandom_range(0, 15);
            bus.dWren      = $urandom_range(0, 1) != 0;
            bus.dFunct3    = 3'($urandom_range(0, 7));
            bus.dWdata     = $urandom;
        end
        @(posedge clk); #1;
        bus.ifReqValid = 1'b0; bus.dReqValid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
